acc_stim_gen: RTL and testbench

- Drive side of the accumulator input interface (number/valid/run) and consumer of its result interface (valid/result).
- Streams an arithmetic run of operands into the accumulator and computes the expected sum internally.
- Checks the returned result and reports pass, fail or timeout.
- Used as the on-chip self-test source in front of acc_core and as reusable bench stimulus.

---
 rtl/acc_stim_gen.sv | 133 +++++++++++++
 tb/tb_acc_stim_gen.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_stim_gen.sv
// Self-test source for the accumulator: streams an arithmetic run of operands,
// tracks the expected sum and checks the returned result or times out.
module acc_stim_gen #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int DWIDTH        = 16,
  parameter int CNT_WIDTH     = 8,
  parameter int TIMEOUT       = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [IN_DATA_WIDTH-1:0] first_i,
  input  logic [CNT_WIDTH-1:0]     count_i,
  output logic [IN_DATA_WIDTH-1:0] number_o,
  output logic                     valid_o,
  output logic                     run_o,
  input  logic                     acc_valid_i,
  input  logic [DWIDTH-1:0]        acc_result_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [DWIDTH-1:0]        expected_o
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [IN_DATA_WIDTH-1:0] r_cur;
  logic [CNT_WIDTH-1:0]     r_rem;
  logic [WW-1:0]            r_wcnt;
  logic [IN_DATA_WIDTH-1:0] r_number;
  logic                     r_valid;
  logic                     r_run;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_pass;
  logic                     r_timeout;
  logic [DWIDTH-1:0]        r_expected;

  logic [IN_DATA_WIDTH-1:0] w_cur_nxt;
  logic                     w_last;
  logic                     w_expired;

  assign w_cur_nxt = r_cur + IN_DATA_WIDTH'(1);
  assign w_last    = (r_rem == CNT_WIDTH'(1));
  assign w_expired = (r_wcnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_rem      <= '0;
      r_wcnt     <= '0;
      r_number   <= '0;
      r_valid    <= 1'b0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_expected <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i && (count_i != '0)) begin
            r_cur      <= first_i;
            r_rem      <= count_i;
            r_number   <= first_i;
            r_valid    <= 1'b1;
            r_run      <= 1'b1;
            r_busy     <= 1'b1;
            r_expected <= '0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          r_expected <= r_expected + DWIDTH'(r_cur);
          r_cur      <= w_cur_nxt;
          r_rem      <= r_rem - CNT_WIDTH'(1);
          // number_o presents the next operand, or holds once the run ends
          if (w_last) begin
            r_valid <= 1'b0;
            r_run   <= 1'b0;
            r_wcnt  <= '0;
            r_state <= S_WAIT;
          end else begin
            r_number <= w_cur_nxt;
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + WW'(1);
          if (acc_valid_i) begin
            r_pass    <= (acc_result_i == r_expected);
            r_timeout <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_expired) begin
            r_pass    <= 1'b0;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign number_o   = r_number;
  assign valid_o    = r_valid;
  assign run_o      = r_run;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign pass_o     = r_pass;
  assign timeout_o  = r_timeout;
  assign expected_o = r_expected;

endmodule

// File: tb/tb_acc_stim_gen.sv
// Bench for acc_stim_gen: accumulator model, operand/result scoreboard,
// directed and random runs on a default and a DWIDTH=10 instance.
module tb_acc_stim_gen;

  localparam int TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_i;
  logic [7:0] first_i;
  logic [7:0] count_i;

  logic [7:0]  number0, number1;
  logic        valid0, valid1, run0, run1, busy0, busy1;
  logic        done0, done1, pass0, pass1, to0, to1;
  logic [15:0] exp0;
  logic [9:0]  exp1;
  logic        acc_valid0, acc_valid1;
  logic [15:0] res0;
  logic [9:0]  res1;

  acc_stim_gen u_dut0 (
    .clk(clk), .reset(reset), .start_i(start_i),
    .first_i(first_i), .count_i(count_i),
    .number_o(number0), .valid_o(valid0), .run_o(run0),
    .acc_valid_i(acc_valid0), .acc_result_i(res0),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0),
    .timeout_o(to0), .expected_o(exp0)
  );

  acc_stim_gen #(.DWIDTH(10)) u_dut1 (
    .clk(clk), .reset(reset), .start_i(start_i),
    .first_i(first_i), .count_i(count_i),
    .number_o(number1), .valid_o(valid1), .run_o(run1),
    .acc_valid_i(acc_valid1), .acc_result_i(res1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .timeout_o(to1), .expected_o(exp1)
  );

  typedef struct {
    logic [15:0] e0;
    logic [9:0]  e1;
    logic        pass;
    logic        tmo;
  } sb_t;

  sb_t        sbq[$];
  logic [7:0] opq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int mode = 0;
  int resp_delay = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference: plain sum of the wrapped operand run
  function automatic sb_t model(input int f, input int c, input int m);
    sb_t    r;
    longint s;
    s = 0;
    for (int i = 0; i < c; i++) s += (f + i) % 256;
    r.e0   = 16'(s % 65536);
    r.e1   = 10'(s % 1024);
    r.pass = (m == 0);
    r.tmo  = (m == 2);
    return r;
  endfunction

  // accumulator model: sums valid operands, answers after run falls
  initial begin
    logic [15:0] s0;
    logic [9:0]  s1;
    bit          seen;
    int          dly;
    acc_valid0 = 1'b0; acc_valid1 = 1'b0;
    res0 = '0; res1 = '0;
    s0 = '0; s1 = '0; seen = 0; dly = -1;
    forever begin
      @(negedge clk);
      acc_valid0 = 1'b0;
      acc_valid1 = 1'b0;
      if (reset) begin
        s0 = '0; s1 = '0; seen = 0; dly = -1;
      end else if (valid0) begin
        s0 = s0 + 16'(number0);
        s1 = s1 + 10'(number1);
        seen = 1;
      end else if (seen) begin
        seen = 0;
        dly = resp_delay;
      end
      if (!reset && dly >= 0) begin
        if (dly == 0) begin
          if (mode != 2) begin
            acc_valid0 = 1'b1;
            acc_valid1 = 1'b1;
            res0 = (mode == 1) ? s0 - 16'd1 : s0;
            res1 = (mode == 1) ? s1 - 10'd1 : s1;
          end
          s0 = '0; s1 = '0; dly = -1;
        end else begin
          dly--;
        end
      end
    end
  end

  // monitor
  initial begin
    bit         pv, pr, pd;
    int         wc;
    sb_t        e;
    logic [7:0] op;
    pv = 0; pr = 0; pd = 0; wc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (valid0) begin
          chk("run_with_valid", run0, 1);
          chk("valid1_match", valid1, 1);
          if (opq.size() == 0) begin
            chk("op_unexpected", valid0, 0);
          end else begin
            op = opq.pop_front();
            chk("number0", number0, op);
            chk("number1", number1, op);
          end
        end
        if (pv && !valid0) chk("ops_left", opq.size(), 0);
        if (pr && !run0) wc = 0;
        else wc++;
        if (done0) begin
          chk("done_once", pd, 0);
          chk("done1", done1, 1);
          if (sbq.size() == 0) begin
            chk("done_unexpected", done0, 0);
          end else begin
            e = sbq.pop_front();
            chk("expected0", exp0, e.e0);
            chk("pass0", pass0, e.pass);
            chk("timeout0", to0, e.tmo);
            chk("expected1", exp1, e.e1);
            chk("pass1", pass1, e.pass);
            chk("timeout1", to1, e.tmo);
            chk("busy_in_done", busy0, 1);
            if (e.tmo) chk("timeout_latency", wc, TO);
          end
        end
      end
      pv = valid0;
      pr = run0;
      pd = done0;
    end
  end

  task automatic issue(input int f, input int c);
    @(negedge clk);
    start_i = 1'b1;
    first_i = 8'(f);
    count_i = 8'(c);
    if (c != 0) begin
      sbq.push_back(model(f, c, mode));
      for (int i = 0; i < c; i++) opq.push_back(8'((f + i) % 256));
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done0, 1);
    @(negedge clk);
  endtask

  task automatic run(input int f, input int c, input int m,
                     input int d, input bit glitch);
    mode = m;
    resp_delay = d;
    issue(f, c);
    if (glitch) begin
      repeat (2) @(negedge clk);
      start_i = 1'b1;
      first_i = 8'd77;
      count_i = 8'd5;
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_done(c + d + TO + 20);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_number"}, number0, 0);
    chk({tag, "_valid"}, valid0, 0);
    chk({tag, "_run"}, run0, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_pass"}, pass0, 0);
    chk({tag, "_timeout"}, to0, 0);
    chk({tag, "_expected"}, exp0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f, c, m, d;
    reset = 1'b1;
    start_i = 1'b0;
    first_i = '0;
    count_i = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    run(1, 100, 0, 2, 0);
    chk("exp_5050", exp0, 5050);
    chk("exp_954", exp1, 954);
    chk("pass_5050", pass0, 1);

    run(1, 100, 1, 0, 0);
    chk("bad_pass", pass0, 0);
    chk("bad_timeout", to0, 0);

    run(250, 10, 0, 1, 0);
    chk("exp_1521", exp0, 1521);

    run(5, 3, 2, 0, 0);
    chk("tmo_flag", to0, 1);
    chk("tmo_pass", pass0, 0);

    issue(20, 0);
    repeat (4) begin
      @(negedge clk);
      chk("cnt0_busy", busy0, 0);
      chk("cnt0_valid", valid0, 0);
      chk("cnt0_done", done0, 0);
    end

    run(10, 20, 0, 3, 1);

    mode = 0;
    resp_delay = 0;
    issue(9, 50);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    opq.delete();
    sbq.delete();
    @(negedge clk);
    chk_zero("midrst");
    @(negedge clk);
    reset = 1'b0;

    run(3, 2, 0, 0, 0);
    chk("exp_7", exp0, 7);
    chk("pass_7", pass0, 1);

    for (int i = 0; i < 20; i++) begin
      f = int'($urandom_range(0, 255));
      c = int'($urandom_range(1, 40));
      m = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      d = int'($urandom_range(0, 5));
      run(f, c, m, d, (i % 4) == 1 && c > 4);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
